traffic_light_controller: RTL and testbench

//  Main intersection FSM: highway (hwy) / farm-road lights with a farm car sensor.

---
 rtl/traffic_light_controller_if.sv | 23 ++
 rtl/traffic_light_controller.sv | 146 ++++++++++++++
 tb/tb_traffic_light_controller.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_controller_if.sv
// Sensor/flash inputs, timer handshake and light outputs of the intersection controller.
interface traffic_light_controller_if;
    logic       i_car_sensor;
    logic       i_flash_mode;
    logic       i_long_timer;
    logic       i_short_timer;
    logic       o_long_time;
    logic       o_short_time;
    logic [1:0] o_hwy_light;
    logic [1:0] o_farm_light;
    logic [2:0] o_state;
    logic       o_fault;

    modport master (
        output i_car_sensor, i_flash_mode, i_long_timer, i_short_timer,
        input  o_long_time, o_short_time, o_hwy_light, o_farm_light, o_state, o_fault
    );

    modport slave (
        input  i_car_sensor, i_flash_mode, i_long_timer, i_short_timer,
        output o_long_time, o_short_time, o_hwy_light, o_farm_light, o_state, o_fault
    );
endinterface

// File: rtl/traffic_light_controller.sv
// Highway/farm-road intersection FSM with all-red clearance, timer request gaps,
// watchdog-to-flash fault handling and a blinking flash mode. All outputs registered.
module traffic_light_controller #(
    parameter int WDOG_CYCLES = 64,
    parameter int FLASH_HALF  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    traffic_light_controller_if.slave   bus
);

    typedef enum logic [2:0] {
        HG    = 3'd0,
        HY    = 3'd1,
        AR1   = 3'd2,
        FG    = 3'd3,
        FY    = 3'd4,
        AR2   = 3'd5,
        FLASH = 3'd6
    } state_t;

    localparam logic [6:0] AGE_MAX    = 7'd127;
    localparam logic [6:0] WDOG_TRIP  = 7'(WDOG_CYCLES - 2);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_HALF - 1);

    state_t     state_q, state_d;
    logic [6:0] age_q, age_d;
    logic [6:0] wdog_q, wdog_d;
    logic       car_pending_q, car_pending_d;
    logic       fault_q, fault_d;
    logic       phase_q, phase_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic       long_d1_q, short_d1_q;
    logic       long_req_q, long_req_d;
    logic       short_req_q, short_req_d;
    logic [1:0] hwy_q, hwy_d;
    logic [1:0] farm_q, farm_d;

    logic timed_long;
    logic expired;
    logic wdog_trip;
    logic entering;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        fcnt_d        = '0;
        hwy_d         = 2'b11;
        farm_d        = 2'b11;

        timed_long = (state_q == HG) || (state_q == FG);
        // Early falling edges are leftovers of the previous state's request.
        expired    = (state_q != FLASH) && (age_q >= 7'd3) &&
                     (timed_long ? (long_d1_q & ~bus.i_long_timer)
                                 : (short_d1_q & ~bus.i_short_timer));
        wdog_trip  = (state_q != FLASH) && (wdog_q >= WDOG_TRIP);

        case (state_q)
            HG:      if (expired && car_pending_q) state_d = HY;
            HY:      if (expired) state_d = AR1;
            AR1:     if (expired) state_d = FG;
            FG:      if (expired) state_d = FY;
            FY:      if (expired) state_d = AR2;
            AR2:     if (expired) state_d = HG;
            FLASH:   if (!bus.i_flash_mode && !fault_q) state_d = AR2;
            default: state_d = AR2;
        endcase
        if ((state_q != FLASH) && (bus.i_flash_mode || wdog_trip)) state_d = FLASH;

        entering = (state_d != state_q);
        fault_d  = fault_q | wdog_trip;
        age_d    = entering ? '0 : ((age_q == AGE_MAX) ? age_q : age_q + 7'd1);
        // The watchdog restarts on every accepted expiry so an idle HG can re-arm forever.
        wdog_d   = (entering || expired) ? '0 : ((wdog_q == AGE_MAX) ? wdog_q : wdog_q + 7'd1);

        if (entering && (state_d == FG))
            car_pending_d = 1'b0;
        else
            car_pending_d = car_pending_q | (bus.i_car_sensor && (state_q != FG));

        if (state_d == FLASH) begin
            if (entering) begin
                phase_d = 1'b1;
            end else if (fcnt_q == FLASH_LAST) begin
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end

        long_req_d  = !entering && ((state_d == HG) || (state_d == FG));
        short_req_d = !entering && (state_d inside {HY, AR1, FY, AR2});

        case (state_d)
            HG:      begin hwy_d = 2'b01; farm_d = 2'b11; end
            HY:      begin hwy_d = 2'b10; farm_d = 2'b11; end
            FG:      begin hwy_d = 2'b11; farm_d = 2'b01; end
            FY:      begin hwy_d = 2'b11; farm_d = 2'b10; end
            FLASH:   begin
                hwy_d  = phase_d ? 2'b10 : 2'b00;
                farm_d = phase_d ? 2'b11 : 2'b00;
            end
            default: begin hwy_d = 2'b11; farm_d = 2'b11; end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q       <= AR2;
            age_q         <= '0;
            wdog_q        <= '0;
            car_pending_q <= 1'b0;
            fault_q       <= 1'b0;
            phase_q       <= 1'b0;
            fcnt_q        <= '0;
            long_d1_q     <= 1'b0;
            short_d1_q    <= 1'b0;
            long_req_q    <= 1'b0;
            short_req_q   <= 1'b0;
            hwy_q         <= 2'b11;
            farm_q        <= 2'b11;
        end else begin
            state_q       <= state_d;
            age_q         <= age_d;
            wdog_q        <= wdog_d;
            car_pending_q <= car_pending_d;
            fault_q       <= fault_d;
            phase_q       <= phase_d;
            fcnt_q        <= fcnt_d;
            long_d1_q     <= bus.i_long_timer;
            short_d1_q    <= bus.i_short_timer;
            long_req_q    <= long_req_d;
            short_req_q   <= short_req_d;
            hwy_q         <= hwy_d;
            farm_q        <= farm_d;
        end
    end

    assign bus.o_long_time  = long_req_q;
    assign bus.o_short_time = short_req_q;
    assign bus.o_hwy_light  = hwy_q;
    assign bus.o_farm_light = farm_q;
    assign bus.o_state      = state_q;
    assign bus.o_fault      = fault_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller with a behavioural 25/4 timing circuit model.
module tb_traffic_light_controller;

    localparam int LONG_CYCLES  = 25;
    localparam int SHORT_CYCLES = 4;

    typedef struct {
        logic [2:0] st;
        logic [1:0] hwy;
        logic [1:0] farm;
        logic [1:0] req;
        int         dwell;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   force_short_low = 1'b0;
    int   lcnt = 0;
    int   scnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    traffic_light_controller_if bus();

    traffic_light_controller #(.WDOG_CYCLES(64), .FLASH_HALF(8)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // Timing circuit model: runs while its request is high, drops for one cycle, re-arms.
    always @(posedge clk) begin
        if (!bus.o_long_time || lcnt == LONG_CYCLES) lcnt <= 0;
        else lcnt <= lcnt + 1;
        if (!bus.o_short_time || scnt == SHORT_CYCLES) scnt <= 0;
        else scnt <= scnt + 1;
    end
    assign bus.i_long_timer  = bus.o_long_time && (lcnt < LONG_CYCLES);
    assign bus.i_short_timer = !force_short_low && bus.o_short_time && (scnt < SHORT_CYCLES);

    function automatic exp_t mk(input logic [2:0] st, input int dwell);
        exp_t e;
        e.st = st;
        e.dwell = dwell;
        case (st)
            3'd0:    begin e.hwy = 2'b01; e.farm = 2'b11; e.req = 2'b10; end
            3'd1:    begin e.hwy = 2'b10; e.farm = 2'b11; e.req = 2'b01; end
            3'd3:    begin e.hwy = 2'b11; e.farm = 2'b01; e.req = 2'b10; end
            3'd4:    begin e.hwy = 2'b11; e.farm = 2'b10; e.req = 2'b01; end
            default: begin e.hwy = 2'b11; e.farm = 2'b11; e.req = 2'b01; end
        endcase
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        force_short_low = 1'b0;
        bus.i_flash_mode = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Observe one state visit from its entry cycle; reports dwell and the request after the gap.
    task automatic watch_visit(input int budget, output int dwell, output logic [1:0] req1, output bit to);
        logic [2:0] st0;
        st0 = bus.o_state;
        dwell = 0;
        req1 = 2'bxx;
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            dwell++;
            if (i == 0) req1 = {bus.o_long_time, bus.o_short_time};
            if (bus.o_state !== st0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic goto_state(input logic [2:0] target, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.o_state === target) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_car_sensor = 1'b1;
        bus.i_flash_mode = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.o_state, bus.o_hwy_light, bus.o_farm_light, bus.o_long_time, bus.o_short_time, bus.o_fault} !== 10'b101_11_11_000) begin
            n_fail++;
            $display("FAIL reset_outputs: got state=%0d hwy=%b farm=%b long=%b short=%b fault=%b, expected 5 11 11 0 0 0",
                     bus.o_state, bus.o_hwy_light, bus.o_farm_light, bus.o_long_time, bus.o_short_time, bus.o_fault);
        end
        bus.i_flash_mode = 1'b0;
        bus.i_car_sensor = 1'b0;
    endtask

    task automatic test_hg_hold();
        int dw; logic [1:0] r1; bit to; int bad;
        exp_t e;
        bus.i_car_sensor = 1'b0;
        do_reset();
        sb.push_back(mk(3'd5, 6));
        e = sb.pop_front();
        watch_visit(40, dw, r1, to);
        n_checks++;
        if (to || dw != e.dwell || r1 !== e.req || bus.o_state !== 3'd0) begin
            n_fail++;
            $display("FAIL ar2_after_reset: got dwell=%0d req=%b next=%0d, expected dwell=%0d req=%b next=0",
                     dw, r1, bus.o_state, e.dwell, e.req);
        end
        n_checks++;
        if ({bus.o_long_time, bus.o_short_time} !== 2'b00 || {bus.o_hwy_light, bus.o_farm_light} !== 4'b0111) begin
            n_fail++;
            $display("FAIL hg_entry: got req=%b lights=%b/%b, expected req=00 lights=01/11",
                     {bus.o_long_time, bus.o_short_time}, bus.o_hwy_light, bus.o_farm_light);
        end
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.o_state !== 3'd0 || bus.o_hwy_light !== 2'b01 || bus.o_farm_light !== 2'b11 ||
                bus.o_long_time !== 1'b1 || bus.o_short_time !== 1'b0 || bus.o_fault !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hg_hold: got %0d bad cycles of 200, expected 0 (last state=%0d fault=%b)", bad, bus.o_state, bus.o_fault);
        end
    endtask

    task automatic test_sensor_pulse();
        int dw; logic [1:0] r1; bit to;
        exp_t e;
        bus.i_car_sensor = 1'b0;
        do_reset();
        goto_state(3'd0, 20, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL pulse_reach_hg: got state=%0d, expected 0", bus.o_state); end
        to = 1'b1;
        dw = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            dw = k;
            if (k == 10) bus.i_car_sensor = 1'b1;
            if (k == 11) bus.i_car_sensor = 1'b0;
            if (bus.o_state !== 3'd0) begin to = 1'b0; break; end
        end
        n_checks++;
        if (to || dw != 27) begin
            n_fail++;
            $display("FAIL pulse_hg_dwell: got %0d (timeout=%0d), expected 27", dw, to);
        end
        sb.push_back(mk(3'd1, 6));
        sb.push_back(mk(3'd2, 6));
        sb.push_back(mk(3'd3, 27));
        sb.push_back(mk(3'd4, 6));
        sb.push_back(mk(3'd5, 6));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (bus.o_state !== e.st || {bus.o_hwy_light, bus.o_farm_light} !== {e.hwy, e.farm}) begin
                n_fail++;
                $display("FAIL pulse_entry: got state=%0d lights=%b/%b, expected state=%0d lights=%b/%b",
                         bus.o_state, bus.o_hwy_light, bus.o_farm_light, e.st, e.hwy, e.farm);
            end
            n_checks++;
            if ({bus.o_long_time, bus.o_short_time} !== 2'b00) begin
                n_fail++;
                $display("FAIL pulse_gap: state %0d got req=%b, expected 00", e.st, {bus.o_long_time, bus.o_short_time});
            end
            watch_visit(80, dw, r1, to);
            n_checks++;
            if (to || dw != e.dwell || r1 !== e.req) begin
                n_fail++;
                $display("FAIL pulse_dwell: state %0d got dwell=%0d req=%b, expected dwell=%0d req=%b",
                         e.st, dw, r1, e.dwell, e.req);
            end
        end
        n_checks++;
        if (bus.o_state !== 3'd0) begin n_fail++; $display("FAIL pulse_return: got state=%0d, expected 0", bus.o_state); end
    endtask

    task automatic test_back_to_back();
        int dw; logic [1:0] r1; bit to; int idx; int period;
        exp_t e;
        bus.i_car_sensor = 1'b1;
        do_reset();
        sb.push_back(mk(3'd5, 6));
        for (int p = 0; p < 2; p++) begin
            sb.push_back(mk(3'd0, 27));
            sb.push_back(mk(3'd1, 6));
            sb.push_back(mk(3'd2, 6));
            sb.push_back(mk(3'd3, 27));
            sb.push_back(mk(3'd4, 6));
            sb.push_back(mk(3'd5, 6));
        end
        idx = 0;
        period = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (bus.o_state !== e.st || {bus.o_hwy_light, bus.o_farm_light} !== {e.hwy, e.farm} ||
                {bus.o_long_time, bus.o_short_time} !== 2'b00) begin
                n_fail++;
                $display("FAIL cont_entry[%0d]: got state=%0d lights=%b/%b req=%b, expected state=%0d lights=%b/%b req=00",
                         idx, bus.o_state, bus.o_hwy_light, bus.o_farm_light, {bus.o_long_time, bus.o_short_time}, e.st, e.hwy, e.farm);
            end
            watch_visit(80, dw, r1, to);
            n_checks++;
            if (to || dw != e.dwell || r1 !== e.req) begin
                n_fail++;
                $display("FAIL cont_dwell[%0d]: got dwell=%0d req=%b, expected dwell=%0d req=%b", idx, dw, r1, e.dwell, e.req);
            end
            if (idx >= 1 && idx <= 6) period += dw;
            idx++;
        end
        n_checks++;
        if (period != 78) begin n_fail++; $display("FAIL cont_period: got %0d, expected 78", period); end
        bus.i_car_sensor = 1'b0;
    endtask

    task automatic test_watchdog();
        int dw; logic [1:0] r1; bit to; int bad;
        bus.i_car_sensor = 1'b1;
        do_reset();
        goto_state(3'd1, 80, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL wdog_reach_hy: got state=%0d, expected 1", bus.o_state); end
        force_short_low = 1'b1;
        watch_visit(100, dw, r1, to);
        n_checks++;
        if (to || dw != 63 || bus.o_state !== 3'd6 || bus.o_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_trip: got age=%0d state=%0d fault=%b, expected 63 6 1", dw, bus.o_state, bus.o_fault);
        end
        n_checks++;
        if ({bus.o_hwy_light, bus.o_farm_light, bus.o_long_time, bus.o_short_time} !== 6'b10_11_00) begin
            n_fail++;
            $display("FAIL flash_entry: got lights=%b/%b req=%b, expected 10/11 00",
                     bus.o_hwy_light, bus.o_farm_light, {bus.o_long_time, bus.o_short_time});
        end
        bad = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (((k / 8) % 2 == 0) ? ({bus.o_hwy_light, bus.o_farm_light} !== 4'b1011)
                                   : ({bus.o_hwy_light, bus.o_farm_light} !== 4'b0000)) bad++;
            if ({bus.o_long_time, bus.o_short_time} !== 2'b00) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL flash_blink: got %0d bad samples, expected 0", bad); end
        force_short_low = 1'b0;
        bus.i_flash_mode = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (bus.o_state !== 3'd6 || bus.o_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_sticky: got state=%0d fault=%b, expected 6 1", bus.o_state, bus.o_fault);
        end
        do_reset();
        n_checks++;
        if (bus.o_state !== 3'd5 || bus.o_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clear: got state=%0d fault=%b, expected 5 0", bus.o_state, bus.o_fault);
        end
    endtask

    task automatic test_flash_mode();
        int dw; logic [1:0] r1; bit to;
        bus.i_car_sensor = 1'b1;
        do_reset();
        goto_state(3'd3, 100, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL flash_reach_fg: got state=%0d, expected 3", bus.o_state); end
        repeat (10) @(negedge clk);
        bus.i_flash_mode = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.o_state, bus.o_hwy_light, bus.o_farm_light, bus.o_long_time, bus.o_short_time, bus.o_fault} !== 10'b110_10_11_000) begin
            n_fail++;
            $display("FAIL flash_force: got state=%0d lights=%b/%b req=%b fault=%b, expected 6 10/11 00 0",
                     bus.o_state, bus.o_hwy_light, bus.o_farm_light, {bus.o_long_time, bus.o_short_time}, bus.o_fault);
        end
        repeat (5) @(negedge clk);
        bus.i_flash_mode = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.o_state, bus.o_hwy_light, bus.o_farm_light, bus.o_long_time, bus.o_short_time} !== 9'b101_11_11_00) begin
            n_fail++;
            $display("FAIL flash_exit: got state=%0d lights=%b/%b req=%b, expected 5 11/11 00",
                     bus.o_state, bus.o_hwy_light, bus.o_farm_light, {bus.o_long_time, bus.o_short_time});
        end
        watch_visit(40, dw, r1, to);
        n_checks++;
        if (to || dw != 6 || r1 !== 2'b01 || bus.o_state !== 3'd0) begin
            n_fail++;
            $display("FAIL flash_to_hg: got dwell=%0d req=%b next=%0d, expected 6 01 0", dw, r1, bus.o_state);
        end
    endtask

    task automatic test_reset_mid_fy();
        int dw; logic [1:0] r1; bit to;
        bus.i_car_sensor = 1'b1;
        do_reset();
        goto_state(3'd4, 150, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL rst_reach_fy: got state=%0d, expected 4", bus.o_state); end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.o_state, bus.o_hwy_light, bus.o_farm_light, bus.o_long_time, bus.o_short_time, bus.o_fault} !== 10'b101_11_11_000) begin
            n_fail++;
            $display("FAIL rst_mid_fy: got state=%0d lights=%b/%b req=%b fault=%b, expected 5 11/11 00 0",
                     bus.o_state, bus.o_hwy_light, bus.o_farm_light, {bus.o_long_time, bus.o_short_time}, bus.o_fault);
        end
        rst_n = 1'b1;
        watch_visit(40, dw, r1, to);
        n_checks++;
        if (to || dw != 6 || bus.o_state !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_then_hg: got dwell=%0d next=%0d, expected 6 0", dw, bus.o_state);
        end
    endtask

    initial begin
        bus.i_car_sensor = 1'b0;
        bus.i_flash_mode = 1'b0;
        test_reset();
        test_hg_hold();
        test_sensor_pulse();
        test_back_to_back();
        test_watchdog();
        test_flash_mode();
        test_reset_mid_fy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
